bnn_layer_sequencer: RTL

Top-level layer sequencer for the BNN inference datapath. Walks the fixed layer order IDLE → READ → CONV1 → CONV2 → CONV3 → FCL1 → FCL2 → IDLE. In each layer it issues exactly the required number of read-enable beats, then holds a fixed drain gap so in-flight data can flush. Sits directly upstream of the weight ROM address controller and the feature memories: it produces the 3-bit layer state and the shared read enable they both consume.

---
 rtl/bnn_pkg.sv | 56 +++++
 rtl/bnn_layer_sequencer_if.sv | 45 ++++
 rtl/bnn_beat_counter.sv | 38 +++
 rtl/bnn_layer_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_pkg
//  Description : Shared definitions for the BNN inference datapath.
//                Holds the layer-state encodings, the default beat counts
//                per layer, the default drain gap and the layer-order helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bnn_pkg;

    // Layer-state code shared with the weight address controller and the
    // feature-memory controllers.
    typedef logic [2:0] layer_t;

    localparam layer_t c_layer_idle  = 3'b000;
    localparam layer_t c_layer_read  = 3'b001;
    localparam layer_t c_layer_conv1 = 3'b010;
    localparam layer_t c_layer_conv2 = 3'b011;
    localparam layer_t c_layer_conv3 = 3'b100;
    localparam layer_t c_layer_fcl1  = 3'b101;
    localparam layer_t c_layer_fcl2  = 3'b110;

    // Phase flag inside a layer: first issue beats, then drain.
    localparam logic c_ph_issue = 1'b0;
    localparam logic c_ph_drain = 1'b1;

    // Counter width used for beat and drain counting.
    localparam int c_cnt_w = 12;

    // Default beat counts per layer.
    localparam logic [11:0] c_read_beats  = 12'd1008;
    localparam logic [11:0] c_conv1_beats = 12'd1008;  // 9 taps x 112
    localparam logic [11:0] c_conv2_beats = 12'd1008;
    localparam logic [11:0] c_conv3_beats = 12'd1008;
    localparam logic [11:0] c_fcl1_beats  = 12'd672;
    localparam logic [11:0] c_fcl2_beats  = 12'd12;

    // Default drain gap after the last beat of every layer (must be >= 1).
    localparam int c_drain_cyc = 4;

    // Fixed layer order; FCL2 wraps back to IDLE.
    function automatic layer_t next_layer(input layer_t cur);
        layer_t nxt;
        case (cur)
            c_layer_read:  nxt = c_layer_conv1;
            c_layer_conv1: nxt = c_layer_conv2;
            c_layer_conv2: nxt = c_layer_conv3;
            c_layer_conv3: nxt = c_layer_fcl1;
            c_layer_fcl1:  nxt = c_layer_fcl2;
            default:       nxt = c_layer_idle;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_layer_sequencer_if
//  Description : Control/status bundle of the BNN layer sequencer.
//                The iABORT wire exists only when BNN_SEQ_ABORT_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface bnn_layer_sequencer_if;
    import bnn_pkg::*;

    logic          iSTART;
    logic          iSTALL;
`ifdef BNN_SEQ_ABORT_EN
    logic          iABORT;
`endif
    layer_t        oSTATE;
    logic          oREAD_EN;
    logic [11:0]   oBEAT;
    logic          oLAYER_DONE;
    logic          oDONE;
    logic          oBUSY;

`ifdef BNN_SEQ_ABORT_EN
    modport master (
        output iSTART, iSTALL, iABORT,
        input  oSTATE, oREAD_EN, oBEAT, oLAYER_DONE, oDONE, oBUSY
    );
    modport slave (
        input  iSTART, iSTALL, iABORT,
        output oSTATE, oREAD_EN, oBEAT, oLAYER_DONE, oDONE, oBUSY
    );
`else
    modport master (
        output iSTART, iSTALL,
        input  oSTATE, oREAD_EN, oBEAT, oLAYER_DONE, oDONE, oBUSY
    );
    modport slave (
        input  iSTART, iSTALL,
        output oSTATE, oREAD_EN, oBEAT, oLAYER_DONE, oDONE, oBUSY
    );
`endif

endinterface
`default_nettype wire

// File: rtl/bnn_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_beat_counter
//  Description : Enable-gated up-counter with synchronous clear. The
//                terminal flag fires on the enabled cycle that holds
//                max_val-1; the counter wraps to zero on that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bnn_beat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt,
    output logic             term
);

    logic [WIDTH-1:0] r_cnt;

    assign term = en && (r_cnt == (max_val - WIDTH'(1)));
    assign cnt  = r_cnt;

    // Count enabled cycles; wrap to zero on the terminal cycle or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || term) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_layer_sequencer
//  Description : Walks IDLE -> READ -> CONV1 -> CONV2 -> CONV3 -> FCL1 ->
//                FCL2 -> IDLE. Each layer issues exactly BEATS read-enable
//                beats (gated by stall), then holds a DRAIN_CYC gap.
//                Optional feature macro: BNN_SEQ_ABORT_EN (adds iABORT).
//  Revision    : 1.0  initial release
// ============================================================================
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter logic [11:0] READ_BEATS  = c_read_beats,
    parameter logic [11:0] CONV1_BEATS = c_conv1_beats,
    parameter logic [11:0] CONV2_BEATS = c_conv2_beats,
    parameter logic [11:0] CONV3_BEATS = c_conv3_beats,
    parameter logic [11:0] FCL1_BEATS  = c_fcl1_beats,
    parameter logic [11:0] FCL2_BEATS  = c_fcl2_beats,
    parameter int          DRAIN_CYC   = c_drain_cyc
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    bnn_layer_sequencer_if.slave   bus
);

    localparam logic [11:0] c_drain_max = 12'(DRAIN_CYC);

    layer_t       r_layer;
    layer_t       w_next_layer;
    logic         r_phase;
    logic         w_next_phase;
    logic [11:0]  w_beat_max;
    logic [11:0]  w_beat_cnt;
    logic [11:0]  w_drain_cnt;
    logic         w_beat_term;
    logic         w_drain_term;
    logic         w_in_issue;
    logic         w_in_drain;
    logic         w_read_en;
    logic         w_abort;
    logic         w_layer_done;

`ifdef BNN_SEQ_ABORT_EN
    assign w_abort = bus.iABORT && (r_layer != c_layer_idle);
`else
    assign w_abort = 1'b0;
`endif

    assign w_in_issue   = (r_layer != c_layer_idle) && (r_phase == c_ph_issue);
    assign w_in_drain   = (r_layer != c_layer_idle) && (r_phase == c_ph_drain);
    // Only the stall input reaches the read enable combinationally.
    assign w_read_en    = w_in_issue && !bus.iSTALL;
    // An abort suppresses the end-of-layer pulse even on the last drain cycle.
    assign w_layer_done = w_drain_term && !w_abort;

    // Select the beat budget of the layer currently being walked.
    always_comb begin
        w_beat_max = READ_BEATS;
        case (r_layer)
            c_layer_read:  w_beat_max = READ_BEATS;
            c_layer_conv1: w_beat_max = CONV1_BEATS;
            c_layer_conv2: w_beat_max = CONV2_BEATS;
            c_layer_conv3: w_beat_max = CONV3_BEATS;
            c_layer_fcl1:  w_beat_max = FCL1_BEATS;
            c_layer_fcl2:  w_beat_max = FCL2_BEATS;
            default:       w_beat_max = READ_BEATS;
        endcase
    end

    bnn_beat_counter #(
        .WIDTH   (c_cnt_w)
    ) u_beat_cnt (
        .clk     (iCLK),
        .rst     (iRST),
        .clr     (w_abort),
        .en      (w_read_en),
        .max_val (w_beat_max),
        .cnt     (w_beat_cnt),
        .term    (w_beat_term)
    );

    bnn_beat_counter #(
        .WIDTH   (c_cnt_w)
    ) u_drain_cnt (
        .clk     (iCLK),
        .rst     (iRST),
        .clr     (w_abort),
        .en      (w_in_drain),
        .max_val (c_drain_max),
        .cnt     (w_drain_cnt),
        .term    (w_drain_term)
    );

    // Layer/phase state register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_layer <= c_layer_idle;
            r_phase <= c_ph_issue;
        end else begin
            r_layer <= w_next_layer;
            r_phase <= w_next_phase;
        end
    end

    // Next layer/phase: abort first, then start, beat exhaustion, drain end.
    always_comb begin
        w_next_layer = r_layer;
        w_next_phase = r_phase;
        if (w_abort) begin
            w_next_layer = c_layer_idle;
            w_next_phase = c_ph_issue;
        end else if (r_layer == c_layer_idle) begin
            w_next_phase = c_ph_issue;
            if (bus.iSTART) begin
                w_next_layer = c_layer_read;
            end
        end else if (r_phase == c_ph_issue) begin
            if (w_beat_term) begin
                w_next_phase = c_ph_drain;
            end
        end else begin
            if (w_drain_term) begin
                w_next_layer = next_layer(r_layer);
                w_next_phase = c_ph_issue;
            end
        end
    end

    // Status outputs derived from the registered state and counters.
    always_comb begin
        bus.oSTATE      = r_layer;
        bus.oREAD_EN    = w_read_en;
        bus.oBEAT       = w_beat_cnt;
        bus.oLAYER_DONE = w_layer_done;
        bus.oDONE       = w_layer_done && (r_layer == c_layer_fcl2);
        bus.oBUSY       = (r_layer != c_layer_idle);
    end

endmodule
`default_nettype wire
